// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore sequencer for the multicycle RISC-V datapath.
// Steps the shared ALU and single memory port through fetch, decode,
// execute, memory and writeback, with memory wait handshake, an illegal
// opcode trap and a retired-instruction counter.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   opcode            IR[6:0], valid from DECODE onward
//   mem_ready         memory completes current read/write this cycle
//   pc_write/_cond    PC load (unconditional / branch-qualified)
//   pc_source         0 = ALU result, 1 = ALUOut
//   ir_write          latch fetched word into IR and PC into old_pc
//   i_or_d            memory address select (0 = PC, 1 = ALUOut)
//   mem_read/_write   memory requests
//   mem_to_register   writeback source (1 = MDR, 0 = ALUOut)
//   reg_write         register file write enable
//   alu_src_a/_b      ALU operand selects
//   alu_op            ALU control class
//   ctrl_sign_extend  immediate format select
//   illegal           trap flag, held until reset
//   instr_done        pulse in the final cycle of an instruction
//   instret           retired-instruction count
//   state             current state encoding (debug)
module multicycle_ctrl_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_register,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       ctrl_sign_extend,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    localparam int unsigned OP_W = 7;
    localparam logic [OP_W-1:0] OP_R      = 7'h33;
    localparam logic [OP_W-1:0] OP_I      = 7'h13;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'h03;
    localparam logic [OP_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'h63;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_TRAP      = 4'd15
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q;

    // Raw strobes before reset gating
    logic pc_write_c, pc_write_cond_c, ir_write_c, mem_read_c;
    logic mem_write_c, reg_write_c, done_c;

    // State and retirement counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (done_c) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Next-state and Moore outputs (mem_ready only qualifies FETCH/MEM waits)
    always_comb begin
        state_d         = state_q;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        ir_write_c      = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        reg_write_c     = 1'b0;
        done_c          = 1'b0;
        pc_source       = 1'b0;
        i_or_d          = 1'b0;
        mem_to_register = 1'b0;
        alu_src_a       = 2'b00;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        illegal         = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = 2'b01;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut from old_pc + imm
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read_c = 1'b1;
                i_or_d     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_c     = 1'b1;
                mem_to_register = 1'b1;
                done_c          = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_c = 1'b1;
                i_or_d      = 1'b1;
                if (mem_ready) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a       = 2'b01;
                alu_op          = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_source       = 1'b1;
                done_c          = 1'b1;
                state_d         = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes and retirement pulse are suppressed while reset is held
    assign pc_write      = pc_write_c      & rst_n;
    assign pc_write_cond = pc_write_cond_c & rst_n;
    assign ir_write      = ir_write_c      & rst_n;
    assign mem_read      = mem_read_c      & rst_n;
    assign mem_write     = mem_write_c     & rst_n;
    assign reg_write     = reg_write_c     & rst_n;
    assign instr_done    = done_c          & rst_n;

    // Immediate format follows opcode in every state
    always_comb begin
        case (opcode)
            OP_STORE:  ctrl_sign_extend = 2'b01;
            OP_BRANCH: ctrl_sign_extend = 2'b10;
            default:   ctrl_sign_extend = 2'b00;
        endcase
    end

    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: each directed cycle pushes its
// expected outputs; a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, pc_source, ir_write, i_or_d;
    logic             mem_read, mem_write, mem_to_register, reg_write;
    logic [1:0]       alu_src_a, alu_src_b, alu_op, ctrl_sign_extend;
    logic             illegal, instr_done;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state;

    multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .opcode           (opcode),
        .mem_ready        (mem_ready),
        .pc_write         (pc_write),
        .pc_write_cond    (pc_write_cond),
        .pc_source        (pc_source),
        .ir_write         (ir_write),
        .i_or_d           (i_or_d),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_to_register  (mem_to_register),
        .reg_write        (reg_write),
        .alu_src_a        (alu_src_a),
        .alu_src_b        (alu_src_b),
        .alu_op           (alu_op),
        .ctrl_sign_extend (ctrl_sign_extend),
        .illegal          (illegal),
        .instr_done       (instr_done),
        .instret          (instret),
        .state            (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       st;
        logic             pcw, pcwc, pcsrc, irw, iod, mr, mw, mtr, rw;
        logic [1:0]       a, b, aop, sx;
        logic             ill, done;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    logic [CNT_W-1:0] exp_cnt;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_checks++;
        if (act !== ex) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, ex);
        end
    endtask

    // Monitor: compare mid-cycle, away from the rising edge
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("state",            32'(state),            32'(mon_e.st));
            chk("pc_write",         32'(pc_write),         32'(mon_e.pcw));
            chk("pc_write_cond",    32'(pc_write_cond),    32'(mon_e.pcwc));
            chk("pc_source",        32'(pc_source),        32'(mon_e.pcsrc));
            chk("ir_write",         32'(ir_write),         32'(mon_e.irw));
            chk("i_or_d",           32'(i_or_d),           32'(mon_e.iod));
            chk("mem_read",         32'(mem_read),         32'(mon_e.mr));
            chk("mem_write",        32'(mem_write),        32'(mon_e.mw));
            chk("mem_to_register",  32'(mem_to_register),  32'(mon_e.mtr));
            chk("reg_write",        32'(reg_write),        32'(mon_e.rw));
            chk("alu_src_a",        32'(alu_src_a),        32'(mon_e.a));
            chk("alu_src_b",        32'(alu_src_b),        32'(mon_e.b));
            chk("alu_op",           32'(alu_op),           32'(mon_e.aop));
            chk("ctrl_sign_extend", 32'(ctrl_sign_extend), 32'(mon_e.sx));
            chk("illegal",          32'(illegal),          32'(mon_e.ill));
            chk("instr_done",       32'(instr_done),       32'(mon_e.done));
            chk("instret",          32'(instret),          32'(mon_e.cnt));
        end
    end

    // One cycle: drive inputs, push the expectation for the hand-listed state
    task automatic cyc(input logic r, input logic [6:0] op, input logic rdy, input logic [3:0] st);
        exp_t e;
        rst_n = r; opcode = op; mem_ready = rdy;
        e = '{st: st, pcw: 0, pcwc: 0, pcsrc: 0, irw: 0, iod: 0, mr: 0, mw: 0,
              mtr: 0, rw: 0, a: 2'b00, b: 2'b00, aop: 2'b00, sx: 2'b00,
              ill: 0, done: 0, cnt: exp_cnt};
        case (st)
            4'd0:  begin e.mr = 1; e.b = 2'b01; e.irw = rdy; e.pcw = rdy; end
            4'd1:  begin e.a = 2'b10; e.b = 2'b10; end
            4'd2:  begin e.a = 2'b01; e.b = 2'b10; end
            4'd3:  begin e.mr = 1; e.iod = 1; end
            4'd4:  begin e.rw = 1; e.mtr = 1; e.done = 1; end
            4'd5:  begin e.mw = 1; e.iod = 1; e.done = rdy; end
            4'd6:  begin e.a = 2'b01; e.aop = 2'b10; end
            4'd7:  begin e.a = 2'b01; e.b = 2'b10; e.aop = 2'b11; end
            4'd8:  begin e.rw = 1; e.done = 1; end
            4'd9:  begin e.a = 2'b01; e.aop = 2'b01; e.pcwc = 1; e.pcsrc = 1; e.done = 1; end
            4'd15: begin e.ill = 1; end
            default: ;
        endcase
        e.sx = (op == 7'h23) ? 2'b01 : (op == 7'h63) ? 2'b10 : 2'b00;
        if (!r) begin
            e.pcw = 0; e.pcwc = 0; e.irw = 0; e.mr = 0; e.mw = 0; e.rw = 0; e.done = 0;
        end
        sb.push_back(e);
        if (!r) exp_cnt = '0;
        else if (e.done) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'h00; mem_ready = 1'b0; exp_cnt = '0;
        // Unchecked first edge brings the state out of power-up
        @(posedge clk); #1;

        // Reset held 3 cycles
        repeat (3) cyc(0, 7'h33, 0, 4'd0);

        // R-type zero wait: 0,1,6,8
        cyc(1, 7'h33, 1, 4'd0); cyc(1, 7'h33, 1, 4'd1);
        cyc(1, 7'h33, 1, 4'd6); cyc(1, 7'h33, 1, 4'd8);

        // I-type: 0,1,7,8
        cyc(1, 7'h13, 1, 4'd0); cyc(1, 7'h13, 1, 4'd1);
        cyc(1, 7'h13, 1, 4'd7); cyc(1, 7'h13, 1, 4'd8);

        // Load: 2 fetch waits, 3 read waits -> 10 cycles
        cyc(1, 7'h03, 0, 4'd0); cyc(1, 7'h03, 0, 4'd0); cyc(1, 7'h03, 1, 4'd0);
        cyc(1, 7'h03, 1, 4'd1); cyc(1, 7'h03, 1, 4'd2);
        cyc(1, 7'h03, 0, 4'd3); cyc(1, 7'h03, 0, 4'd3); cyc(1, 7'h03, 0, 4'd3);
        cyc(1, 7'h03, 1, 4'd3); cyc(1, 7'h03, 1, 4'd4);

        // Store with one write wait, then branch back-to-back
        cyc(1, 7'h23, 1, 4'd0); cyc(1, 7'h23, 1, 4'd1); cyc(1, 7'h23, 1, 4'd2);
        cyc(1, 7'h23, 0, 4'd5); cyc(1, 7'h23, 1, 4'd5);
        cyc(1, 7'h63, 1, 4'd0); cyc(1, 7'h63, 1, 4'd1); cyc(1, 7'h63, 1, 4'd9);

        // Illegal opcode: trap holds 20 cycles regardless of inputs
        cyc(1, 7'h7F, 1, 4'd0); cyc(1, 7'h7F, 1, 4'd1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, (i % 2 == 0) ? 7'h33 : 7'h03, 1'(i % 3 == 0), 4'd15);
        end
        // Reset clears the trap
        cyc(0, 7'h33, 1, 4'd15);

        // Counter wrap: 17 branches from 0 -> 1 (mod 16)
        for (int i = 0; i < 17; i++) begin
            cyc(1, 7'h63, 1, 4'd0); cyc(1, 7'h63, 1, 4'd1); cyc(1, 7'h63, 1, 4'd9);
        end

        // One more R-type so the counter is non-zero before aborting
        cyc(1, 7'h33, 1, 4'd0); cyc(1, 7'h33, 1, 4'd1);
        cyc(1, 7'h33, 1, 4'd6); cyc(1, 7'h33, 1, 4'd8);

        // Reset during a MEM_READ wait
        cyc(1, 7'h03, 1, 4'd0); cyc(1, 7'h03, 1, 4'd1); cyc(1, 7'h03, 1, 4'd2);
        cyc(1, 7'h03, 0, 4'd3);
        cyc(0, 7'h03, 1, 4'd3);

        // Reset during MEM_WRITE with mem_ready high: no retirement
        cyc(1, 7'h23, 1, 4'd0); cyc(1, 7'h23, 1, 4'd1); cyc(1, 7'h23, 1, 4'd2);
        cyc(1, 7'h23, 0, 4'd5);
        cyc(0, 7'h23, 1, 4'd5);

        // Fetch restarts right after release
        cyc(1, 7'h13, 0, 4'd0);

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Multicycle sequencer for the RISC-V core: a Moore state machine that drives the shared-ALU, single-memory-port datapath through fetch, decode, execute, memory and writeback steps. It decodes the same five opcode classes as the single-cycle control unit and emits the same `alu_op` and `ctrl_sign_extend` encodings, so the existing ALU control and branch control blocks connect unchanged. It also adds a memory wait handshake, an illegal-opcode trap and a retired-instruction counter.

## Interface
- `CNT_W`, 32: width of retired-instruction counter.
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `opcode` input 7: IR[6:0]; valid from DECODE onward.
- `mem_ready` input 1: memory completes the current read or write this cycle.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load qualified externally by `branch_control.branch`.
- `pc_source` output 1: 0 = ALU result (PC+4); 1 = ALUOut (branch target).
- `ir_write` output 1: latch memory data into IR and current PC into old_pc.
- `i_or_d` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `mem_to_register` output 1: 1 = MDR, 0 = ALUOut to register file.
- `reg_write` output 1: register file write enable.
- `alu_src_a` output 2: 00 = PC, 01 = rs1, 10 = old_pc.
- `alu_src_b` output 2: 00 = rs2, 01 = constant 4, 10 = immediate.
- `alu_op` output 2: 00 = add, 01 = branch compare, 10 = R-type, 11 = I-type.
- `ctrl_sign_extend` output 2: 00 = I/load, 01 = S, 10 = B.
- `illegal` output 1: sticky trap flag.
- `instr_done` output 1: one-cycle pulse when an instruction retires.
- `instret` output CNT_W: retired-instruction count.
- `state` output 4: current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, TRAP=15. Unused codes go to FETCH on the next edge.
- Any output not listed for a state is 0.
- **FETCH**
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00, `pc_source`=0.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- **DECODE**
  - Drives `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00, which precomputes the branch target into ALUOut.
  - Next state by opcode: 0x33 → EXEC_R, 0x13 → EXEC_I, 0x03 or 0x23 → MEM_ADDR, 0x63 → BRANCH, anything else → TRAP.
- **MEM_ADDR**
  - Drives `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00.
  - Next state: MEM_READ for 0x03, MEM_WRITE for 0x23.
- **MEM_READ**
  - Drives `mem_read`=1, `i_or_d`=1.
  - Holds until `mem_ready`=1, then goes to MEM_WB.
- **MEM_WB**
  - Drives `reg_write`=1, `mem_to_register`=1.
  - Goes to FETCH and retires the instruction.
- **MEM_WRITE**
  - Drives `mem_write`=1, `i_or_d`=1.
  - Holds until `mem_ready`=1, then goes to FETCH and retires the instruction.
- **EXEC_R**
  - Drives `alu_src_a`=01, `alu_src_b`=00, `alu_op`=10, then goes to ALU_WB.
- **EXEC_I**
  - Drives `alu_src_a`=01, `alu_src_b`=10, `alu_op`=11, then goes to ALU_WB.
- **ALU_WB**
  - Drives `reg_write`=1, `mem_to_register`=0.
  - Goes to FETCH and retires the instruction.
- **BRANCH**
  - Drives `alu_src_a`=01, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=1.
  - Goes to FETCH and retires the instruction.
- **TRAP**
  - `illegal`=1 and all strobes 0.
  - Remains in TRAP until reset.
  - `opcode` changes are ignored.
- `ctrl_sign_extend` is decoded combinationally from `opcode` in every state: 0x23 → 01, 0x63 → 10, otherwise 00.
- **Retirement**
  - `instr_done` is 1 in the final cycle of an instruction: MEM_WB, ALU_WB, BRANCH, or MEM_WRITE with `mem_ready`=1.
  - `instret` increments by 1 on that edge and wraps modulo 2^CNT_W.

## Timing
- **Reset**
  - On a rising edge with `rst_n`=0: state becomes FETCH and `instret` becomes 0.
  - While `rst_n`=0, every strobe (`pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `reg_write`) and `instr_done` is forced to 0.
  - `illegal` is 0 out of reset.
  - Reset asserted mid-instruction (including during a `mem_ready` wait, or while in TRAP) aborts the instruction with no retirement. Fetch restarts in the first cycle after `rst_n` returns high.
- **Latency with zero-wait memory** (`mem_ready` held high), cycles from FETCH entry to the next FETCH entry:
  - R and I: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
- Each wait cycle adds exactly 1. `mem_read`/`mem_write` and the address select stay stable throughout the wait.
- All outputs are combinational from registered state plus `mem_ready`, `opcode` and `rst_n`. There are no combinational paths from `mem_ready` to any state register other than through the next-state logic.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → `state`=0, all strobes 0, `instret`=0. First cycle after release: `mem_read`=1, `i_or_d`=0.
- **R-type, zero wait:** `opcode`=0x33, `mem_ready`=1 → state sequence 0,1,6,8,0; `reg_write`=1 only in state 8; `instret`=1 after 4 cycles.
- **Load with wait states:** `opcode`=0x03, `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEM_READ → 10 cycles total; `mem_to_register`=1 with `reg_write`=1 in state 4.
- **Store and branch back-to-back:** store then branch → `mem_write`=1 only in state 5 with `i_or_d`=1; branch asserts `pc_write_cond`=1, `pc_source`=1, `alu_op`=01, `ctrl_sign_extend`=10; `instret`=2.
- **Illegal opcode:** `opcode`=0x7F in DECODE → state 15, `illegal`=1 held for 20 cycles with no strobes and no `instret` change. Reset clears `illegal`.
- **Counter wrap and mid-wait reset:** with `CNT_W`=4, retire 17 instructions → `instret`=1. Assert reset during a MEM_READ wait → no `instr_done` pulse and `instret`=0.
